// File: rtl/sap_loader_if.sv
// Byte-stream valid/ready channel feeding the SAP-1 program loader.
// The master drives bytes and the slave (loader) answers with in_ready.
interface sap_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sap_loader.sv
// SAP-1 program loader: takes a length/program/checksum frame, writes it into
// the 16-byte RAM, and holds the CPU in reset until a good frame arrives.
module sap_loader (
    input  logic              clk,
    input  logic              reset_n,
    sap_loader_if.slave       s,
    input  logic              halted,
    output logic              ram_we,
    output logic [3:0]        ram_addr,
    output logic [7:0]        ram_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        CSUM,
        RELEASE,
        RUN,
        DONE,
        ERROR
    } state_t;

    state_t     state_q;
    logic [7:0] sum_q;
    logic [3:0] addr_q;
    logic [4:0] remaining_q;
    logic       ram_we_q;
    logic [3:0] ram_addr_q;
    logic [7:0] ram_data_q;
    logic       cpu_reset_q;
    logic       done_q;
    logic       error_q;

    logic       hs;
    logic       len_ok;
    logic [7:0] sum_d;

    always_comb begin
        s.in_ready = (state_q == IDLE) || (state_q == DATA) || (state_q == CSUM) ||
                     (state_q == DONE) || (state_q == ERROR);
        hs     = s.in_valid && s.in_ready;
        len_ok = (s.in_data != 8'd0) && (s.in_data <= 8'd16);
        sum_d  = sum_q + s.in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            case (state_q)
                // IDLE, DONE and ERROR all treat the next accepted byte as a length.
                IDLE, DONE, ERROR: begin
                    if (hs) begin
                        cpu_reset_q <= 1'b1;
                        done_q      <= 1'b0;
                        if (len_ok) begin
                            state_q     <= DATA;
                            remaining_q <= s.in_data[4:0];
                            sum_q       <= '0;
                            addr_q      <= '0;
                            error_q     <= 1'b0;
                        end else begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (hs) begin
                        ram_we_q    <= 1'b1;
                        ram_addr_q  <= addr_q;
                        ram_data_q  <= s.in_data;
                        addr_q      <= addr_q + 4'd1;
                        sum_q       <= sum_d;
                        remaining_q <= remaining_q - 5'd1;
                        if (remaining_q == 5'd1) begin
                            state_q <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (hs) begin
                        if (sum_d == 8'd0) begin
                            state_q <= RELEASE;
                        end else begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    state_q     <= RUN;
                    cpu_reset_q <= 1'b0;
                end
                RUN: begin
                    if (halted) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_sap_loader.sv
// Directed bench for sap_loader: expected RAM writes go into a queue that a
// strobe monitor drains; status outputs are checked directly by the stimulus.
module tb_sap_loader;

    logic       clk;
    logic       reset_n;
    logic       halted;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       cpu_reset;
    logic       done;
    logic       error;

    sap_loader_if sif ();

    sap_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s         (sif.slave),
        .halted    (halted),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write scoreboard: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ram_addr, ram_data);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_addr", {28'd0, ram_addr}, {28'd0, w.a});
                check("write_data", {24'd0, ram_data}, {24'd0, w.d});
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int unsigned n;
        n = 0;
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_data  = b;
        while (!sif.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!sif.in_ready) begin
            check("send_timeout", 32'd0, 32'd1);
            sif.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            sif.in_valid = 1'b0;
        end
    endtask

    task automatic send_wr(input logic [3:0] a, input logic [7:0] b);
        exp_q.push_back('{a: a, d: b});
        send(b);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Called right after the checksum handshake edge E.
    task automatic release_check(input string tag);
        @(negedge clk);
        check({tag, "_rel_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
        check({tag, "_rel_in_ready"}, {31'd0, sif.in_ready}, 32'd0);
        @(negedge clk);
        check({tag, "_run_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
        check({tag, "_run_in_ready"}, {31'd0, sif.in_ready}, 32'd0);
    endtask

    task automatic halt_check(input string tag);
        halted = 1'b1;
        @(negedge clk);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_done_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
        check({tag, "_done_in_ready"}, {31'd0, sif.in_ready}, 32'd1);
        halted = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n      = 1'b0;
        halted       = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_data  = '0;
        idle(2);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_in_ready", {31'd0, sif.in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Good load: 3 bytes, checksum 76.
        send(8'h03);
        send_wr(4'h0, 8'h5A);
        send_wr(4'h1, 8'h01);
        send_wr(4'h2, 8'h2F);
        send(8'h76);
        release_check("good");
        halt_check("good");

        // Bad checksum, then a good 1-byte frame; leaving DONE reasserts cpu_reset.
        send(8'h02);
        check("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("reload_done", {31'd0, done}, 32'd0);
        send_wr(4'h0, 8'h10);
        send_wr(4'h1, 8'h20);
        send(8'h00);
        check("badsum_error", {31'd0, error}, 32'd1);
        check("badsum_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        idle(3);
        check("badsum_hold_error", {31'd0, error}, 32'd1);
        send(8'h01);
        check("err_clear", {31'd0, error}, 32'd0);
        send_wr(4'h0, 8'hFF);
        send(8'h01);
        release_check("recover");
        halt_check("recover");

        // Bad lengths: 00 from DONE, then 11 from ERROR.
        send(8'h00);
        check("len0_error", {31'd0, error}, 32'd1);
        check("len0_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("len0_done", {31'd0, done}, 32'd0);
        send(8'h11);
        check("len17_error", {31'd0, error}, 32'd1);
        check("len17_in_ready", {31'd0, sif.in_ready}, 32'd1);

        // Full 16-byte load with stalls; halted held high must be ignored until RUN.
        halted = 1'b1;
        send(8'h10);
        check("full_error_clear", {31'd0, error}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'(i * 17);
            send_wr(4'(i), b);
            idle(1);
        end
        check("full_done_ignored", {31'd0, done}, 32'd0);
        check("full_cpu_reset_held", {31'd0, cpu_reset}, 32'd1);
        send(8'h08);
        release_check("full");
        halt_check("full");

        // Reload a single byte from DONE.
        send(8'h01);
        check("one_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("one_done", {31'd0, done}, 32'd0);
        send_wr(4'h0, 8'h42);
        send(8'hBE);
        release_check("one");
        halt_check("one");

        // Reset after 2 of 5 data bytes.
        send(8'h05);
        send_wr(4'h0, 8'hA1);
        send_wr(4'h1, 8'hA2);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("mid_rst_ram_addr", {28'd0, ram_addr}, 32'd0);
        check("mid_rst_ram_data", {24'd0, ram_data}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_error", {31'd0, error}, 32'd0);
        check("mid_rst_in_ready", {31'd0, sif.in_ready}, 32'd1);
        idle(2);
        reset_n = 1'b1;
        send(8'h33);
        check("post_rst_len_error", {31'd0, error}, 32'd1);
        idle(4);

        check("writes_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
